// File: rtl/dual_issue_queue_pkg.sv
// Shared decode-entry type and pairing predicates for the dual-issue queue.
package dual_issue_queue_pkg;

  localparam logic [3:0] BR_NONE   = 4'd0;
  localparam logic [2:0] CSR_NONE  = 3'd0;
  localparam logic [3:0] LDST_NONE = 4'd0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [3:0]  br_type;
    logic [2:0]  csr_type;
    logic [3:0]  ldst_type;
    logic        mem_we;
    logic        o_inst_lawful;
    logic        ecode_we;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
  } PC_set;

  typedef enum logic [1:0] {
    ISSUE_NONE,
    ISSUE_A,
    ISSUE_AB
  } issue_mode_t;

  // Head may lead a pair: no control transfer, CSR access or exception.
  function automatic logic is_head_pairable(input PC_set s);
    return (s.br_type == BR_NONE) && (s.csr_type == CSR_NONE) &&
           s.o_inst_lawful && !s.ecode_we;
  endfunction

  // Entry may ride the B channel: plain ALU work only.
  function automatic logic is_b_capable(input PC_set s);
    return (s.br_type == BR_NONE) && (s.csr_type == CSR_NONE) &&
           (s.ldst_type == LDST_NONE) && !s.mem_we &&
           s.o_inst_lawful && !s.ecode_we;
  endfunction

endpackage

// File: rtl/dual_issue_check.sv
// Combinational pairing decision for the two oldest queue entries.
module dual_issue_check
  import dual_issue_queue_pkg::*;
(
  input  PC_set i_head,
  input  PC_set i_next,
  input  logic  i_pair_avail,
  output logic  o_pair_ok
);

  logic w_raw;
  logic w_unused;

  assign w_unused = ^{i_head.pc, i_head.inst, i_head.ldst_type, i_head.mem_we,
                      i_head.rf_raddr1, i_head.rf_raddr2,
                      i_next.pc, i_next.inst, i_next.rf_we, i_next.rf_rd};

  always_comb begin
    w_raw = i_head.rf_we && (i_head.rf_rd != 5'd0) &&
            ((i_head.rf_rd == i_next.rf_raddr1) || (i_head.rf_rd == i_next.rf_raddr2));
    o_pair_ok = i_pair_avail && is_head_pairable(i_head) &&
                is_b_capable(i_next) && !w_raw;
  end

endmodule

// File: rtl/dual_issue_queue.sv
// Decode-side instruction queue feeding the A/B issue registers, up to two in and two out per cycle.
module dual_issue_queue
  import dual_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_flush,
  input  logic  i_stall,
  input  logic  i_valid0,
  input  logic  i_valid1,
  input  PC_set i_set0,
  input  PC_set i_set1,
  output logic  o_ready,
  output logic  o_valid_a,
  output PC_set o_set_a,
  output logic  o_valid_b,
  output PC_set o_set_b
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  PC_set       r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic        r_valid_a;
  logic        r_valid_b;
  PC_set       r_set_a;
  PC_set       r_set_b;

  logic        w_ready;
  logic        w_enq0;
  logic        w_enq1;
  logic [CW-1:0] w_enq_n;
  logic [CW-1:0] w_deq_n;
  logic [PW-1:0] w_next_idx;
  logic        w_pair_ok;
  issue_mode_t w_mode;

  assign w_next_idx = r_head + PW'(1);

  dual_issue_check u_check (
    .i_head       (r_mem[r_head]),
    .i_next       (r_mem[w_next_idx]),
    .i_pair_avail (r_count >= CW'(2)),
    .o_pair_ok    (w_pair_ok)
  );

  always_comb begin
    w_ready = (CW'(DEPTH) - r_count) >= CW'(2);
    w_enq0  = w_ready && i_valid0;
    w_enq1  = w_enq0 && i_valid1;
    w_enq_n = CW'(w_enq0) + CW'(w_enq1);
    w_mode  = ISSUE_NONE;
    if (!i_stall && (r_count != '0))
      w_mode = w_pair_ok ? ISSUE_AB : ISSUE_A;
    case (w_mode)
      ISSUE_AB: w_deq_n = CW'(2);
      ISSUE_A:  w_deq_n = CW'(1);
      default:  w_deq_n = '0;
    endcase
  end

  // Storage needs no reset; validity is tracked solely by head/count.
  always_ff @(posedge clk) begin
    if (!i_flush) begin
      if (w_enq0) r_mem[r_tail]          <= i_set0;
      if (w_enq1) r_mem[r_tail + PW'(1)] <= i_set1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
      r_set_a   <= '0;
      r_set_b   <= '0;
    end else if (i_flush) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
    end else begin
      r_tail  <= r_tail + PW'(w_enq_n);
      r_head  <= r_head + PW'(w_deq_n);
      r_count <= r_count + w_enq_n - w_deq_n;
      if (!i_stall) begin
        r_valid_a <= (w_mode != ISSUE_NONE);
        r_valid_b <= (w_mode == ISSUE_AB);
        if (w_mode != ISSUE_NONE) begin
          r_set_a <= r_mem[r_head];
          r_set_b <= r_mem[w_next_idx];
        end
      end
    end
  end

  assign o_ready   = w_ready;
  assign o_valid_a = r_valid_a;
  assign o_valid_b = r_valid_b;
  assign o_set_a   = r_set_a;
  assign o_set_b   = r_set_b;

endmodule
